// File: rtl/apb_text_console.sv
// Purpose : APB master that turns a character stream into {colour,char} writes on an 80x30 text map.
// Latency : printable char -> SETUP next cycle, ACCESS after that, ends on pready; control codes take 1 cycle.
// Backpres: char_ready_o low whenever a transfer or clear is in flight; APB waits on apb_pready_i.
//
// Ports: clk_i/rst_i (sync, active-high); char_valid_i/char_i/color_i/char_ready_o request side;
//        clr_req_i clear-screen pulse; busy_o, cursor_col_o, cursor_row_o, err_o status;
//        apb_* standard APB master write signals.
// Optional: define APB_TEXT_CONSOLE_TIMEOUT_EN to abandon ACCESS after TIMEOUT_CYCLES without pready.
module apb_text_console #(
  parameter int unsigned APB_ADDR_WIDTH = 13,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned ADDR_SHIFT     = 0,
  parameter int unsigned COLS           = 80,
  parameter int unsigned ROWS           = 30,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      char_valid_i,
  input  logic [7:0]                char_i,
  input  logic [7:0]                color_i,
  output logic                      char_ready_o,
  input  logic                      clr_req_i,
  output logic                      busy_o,
  output logic [6:0]                cursor_col_o,
  output logic [4:0]                cursor_row_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);

  localparam int unsigned CELLS   = COLS * ROWS;
  localparam int unsigned IDX_W   = $clog2(CELLS);
  localparam int unsigned AFULL_W = IDX_W + ADDR_SHIFT;
  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);

  // Cursor registers are 7/5 bits wide and the data word carries 16 payload bits.
  if (COLS < 1 || COLS > 128 || ROWS < 1 || ROWS > 32 ||
      APB_DATA_WIDTH < 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_text_console: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CLR_NEXT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_col;
  logic [4:0]       r_row;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_data;
  logic             r_clr;
  logic             r_err;

  logic             w_idle;
  logic             w_clr_start;
  logic             w_accept;
  logic             w_printable;
  logic             w_timeout;
  logic             w_xfer_done;
  logic             w_last_cell;
  logic [IDX_W-1:0] w_cell_idx;
  logic [4:0]       w_row_inc;
  logic [AFULL_W-1:0] w_addr_full;

  assign w_idle      = (r_state == IDLE);
  // Clear wins over a character presented in the same cycle.
  assign w_clr_start = w_idle && clr_req_i;
  assign w_accept    = w_idle && char_valid_i && !clr_req_i;
  assign w_printable = (char_i >= 8'h20) && (char_i <= 8'h7E);
  assign w_xfer_done = (r_state == ACCESS) && (apb_pready_i || w_timeout);
  assign w_last_cell = (r_idx == IDX_W'(CELLS - 1));
  assign w_cell_idx  = IDX_W'(r_row) * IDX_W'(COLS) + IDX_W'(r_col);
  // No scrolling: the row simply wraps back to the top.
  assign w_row_inc   = (r_row == ROW_LAST) ? 5'd0 : r_row + 5'd1;

`ifdef APB_TEXT_CONSOLE_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] r_tmo;

  // Counts ACCESS cycles already spent; fires on the last permitted one.
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != ACCESS) begin
      r_tmo <= '0;
    end else if (!w_timeout) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign w_timeout = !apb_pready_i && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_clr_start || (w_accept && w_printable)) begin
          w_next = SETUP;
        end
      end
      SETUP:    w_next = ACCESS;
      ACCESS: begin
        if (w_xfer_done) begin
          w_next = r_clr ? CLR_NEXT : IDLE;
        end
      end
      CLR_NEXT: w_next = w_last_cell ? IDLE : SETUP;
      default:  w_next = IDLE;
    endcase
  end

  // Cursor, transfer payload and error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_col  <= '0;
      r_row  <= '0;
      r_idx  <= '0;
      r_data <= '0;
      r_clr  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_clr_start) begin
            r_data <= {color_i, 8'h20};
            r_idx  <= '0;
            r_clr  <= 1'b1;
          end else if (w_accept) begin
            if (w_printable) begin
              r_data <= {color_i, char_i};
              r_idx  <= w_cell_idx;
              r_clr  <= 1'b0;
            end else begin
              case (char_i)
                8'h0A: begin
                  r_col <= '0;
                  r_row <= w_row_inc;
                end
                8'h0D: r_col <= '0;
                8'h08: if (r_col != '0) r_col <= r_col - 7'd1;
                default: ;
              endcase
            end
          end
        end
        ACCESS: begin
          if (w_xfer_done) begin
            if ((apb_pready_i && apb_pslverr_i) || w_timeout) begin
              r_err <= 1'b1;
            end
            if (!r_clr) begin
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= w_row_inc;
              end else begin
                r_col <= r_col + 7'd1;
              end
            end
          end
        end
        CLR_NEXT: begin
          if (w_last_cell) begin
            r_col <= '0;
            r_row <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Excess high address bits beyond APB_ADDR_WIDTH are dropped by the cast.
  assign w_addr_full   = AFULL_W'(r_idx) << ADDR_SHIFT;
  assign apb_paddr_o   = APB_ADDR_WIDTH'(w_addr_full);
  assign apb_pwdata_o  = APB_DATA_WIDTH'(r_data);
  assign apb_psel_o    = (r_state == SETUP) || (r_state == ACCESS);
  assign apb_penable_o = (r_state == ACCESS);
  assign apb_pwrite_o  = apb_psel_o;

  assign char_ready_o  = !rst_i && w_idle && !clr_req_i;
  assign busy_o        = !w_idle;
  assign cursor_col_o  = r_col;
  assign cursor_row_o  = r_row;
  assign err_o         = r_err;

endmodule

// File: tb/tb_apb_text_console.sv
// Bench for apb_text_console: directed vector table plus hand-written multi-cycle sequences.
module tb_apb_text_console;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        char_valid_i = 1'b0;
  logic [7:0]  char_i = 8'h00;
  logic [7:0]  color_i = 8'h00;
  logic        char_ready_o;
  logic        clr_req_i = 1'b0;
  logic        busy_o;
  logic [6:0]  cursor_col_o;
  logic [4:0]  cursor_row_o;
  logic        err_o;
  logic [12:0] apb_paddr_o;
  logic [31:0] apb_pwdata_o;
  logic        apb_pwrite_o;
  logic        apb_psel_o;
  logic        apb_penable_o;
  logic        apb_pready_i = 1'b0;
  logic        apb_pslverr_i = 1'b0;

  always #5 clk_i = ~clk_i;

  apb_text_console #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .char_valid_i(char_valid_i), .char_i(char_i), .color_i(color_i),
    .char_ready_o(char_ready_o), .clr_req_i(clr_req_i), .busy_o(busy_o),
    .cursor_col_o(cursor_col_o), .cursor_row_o(cursor_row_o), .err_o(err_o),
    .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o), .apb_pwrite_o(apb_pwrite_o),
    .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o),
    .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: answers each ACCESS after slv_wait wait cycles and logs each write it grants.
  int          slv_wait = 0;
  bit          slv_err  = 1'b0;
  bit          slv_hang = 1'b0;
  int          wcnt     = 0;
  int          sel_cnt  = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk_i) begin
    if (apb_psel_o) sel_cnt++;
    if (apb_psel_o && apb_penable_o && !slv_hang) begin
      if (wcnt >= slv_wait) begin
        apb_pready_i  = 1'b1;
        apb_pslverr_i = slv_err;
        wr_addr.push_back(32'(apb_paddr_o));
        wr_data.push_back(apb_pwdata_o);
      end else begin
        apb_pready_i  = 1'b0;
        apb_pslverr_i = 1'b0;
        wcnt++;
      end
    end else begin
      apb_pready_i  = 1'b0;
      apb_pslverr_i = 1'b0;
      wcnt = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    char_valid_i = 1'b0;
    clr_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Presents one char at a negedge, returns on the negedge after it was accepted.
  task automatic send(input logic [7:0] c, input logic [7:0] co);
    int n = 0;
    @(negedge clk_i);
    while (!char_ready_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (!char_ready_o) chk("ready_wait", 32'(char_ready_o), 32'd1);
    char_valid_i = 1'b1;
    char_i = c;
    color_i = co;
    @(negedge clk_i);
    char_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic [7:0]  co;
    int          ecol;
    int          erow;
    bit          ewr;
    logic [31:0] eaddr;
    logic [31:0] edata;
  } vec_t;

  vec_t tv[15];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int s0;
    int bad;
    int acc;

    // Sequence starting at (0,0) after reset; slave answers with no wait states.
    tv[0]  = '{8'h41, 8'h1F, 1, 0, 1'b1, 32'd0,   32'h1F41};
    tv[1]  = '{8'h42, 8'h07, 2, 0, 1'b1, 32'd1,   32'h0742};
    tv[2]  = '{8'h0A, 8'h00, 0, 1, 1'b0, 32'd0,   32'h0};
    tv[3]  = '{8'h78, 8'h4E, 1, 1, 1'b1, 32'd80,  32'h4E78};
    tv[4]  = '{8'h7E, 8'h01, 2, 1, 1'b1, 32'd81,  32'h017E};
    tv[5]  = '{8'h08, 8'h00, 1, 1, 1'b0, 32'd0,   32'h0};
    tv[6]  = '{8'h08, 8'h00, 0, 1, 1'b0, 32'd0,   32'h0};
    tv[7]  = '{8'h08, 8'h00, 0, 1, 1'b0, 32'd0,   32'h0};
    tv[8]  = '{8'h20, 8'hFF, 1, 1, 1'b1, 32'd80,  32'hFF20};
    tv[9]  = '{8'h07, 8'h00, 1, 1, 1'b0, 32'd0,   32'h0};
    tv[10] = '{8'h7F, 8'h00, 1, 1, 1'b0, 32'd0,   32'h0};
    tv[11] = '{8'h1F, 8'h00, 1, 1, 1'b0, 32'd0,   32'h0};
    tv[12] = '{8'h0D, 8'h00, 0, 1, 1'b0, 32'd0,   32'h0};
    tv[13] = '{8'h0A, 8'h00, 0, 2, 1'b0, 32'd0,   32'h0};
    tv[14] = '{8'h21, 8'h33, 1, 2, 1'b1, 32'd160, 32'h3321};

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ready",   32'(char_ready_o),  32'd0);
    chk("rst_psel",    32'(apb_psel_o),    32'd0);
    chk("rst_penable", 32'(apb_penable_o), 32'd0);
    chk("rst_pwrite",  32'(apb_pwrite_o),  32'd0);
    chk("rst_busy",    32'(busy_o),        32'd0);
    chk("rst_err",     32'(err_o),         32'd0);
    chk("rst_col",     32'(cursor_col_o),  32'd0);
    chk("rst_row",     32'(cursor_row_o),  32'd0);
    chk("rst_paddr",   32'(apb_paddr_o),   32'd0);
    chk("rst_pwdata",  apb_pwdata_o,       32'd0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", 32'(char_ready_o), 32'd1);

    // First transaction, one wait state
    slv_wait = 1;
    send(8'h41, 8'h1F);
    chk("t1_setup_psel",    32'(apb_psel_o),    32'd1);
    chk("t1_setup_penable", 32'(apb_penable_o), 32'd0);
    chk("t1_setup_pwrite",  32'(apb_pwrite_o),  32'd1);
    chk("t1_setup_paddr",   32'(apb_paddr_o),   32'd0);
    chk("t1_setup_pwdata",  apb_pwdata_o,       32'h0000_1F41);
    chk("t1_setup_ready",   32'(char_ready_o),  32'd0);
    @(negedge clk_i);
    chk("t1_access_penable", 32'(apb_penable_o), 32'd1);
    chk("t1_access_psel",    32'(apb_psel_o),    32'd1);
    @(negedge clk_i);
    chk("t1_wait_penable", 32'(apb_penable_o), 32'd1);
    chk("t1_wait_pwdata",  apb_pwdata_o,       32'h0000_1F41);
    @(negedge clk_i);
    chk("t1_done_psel",  32'(apb_psel_o),   32'd0);
    chk("t1_done_col",   32'(cursor_col_o), 32'd1);
    chk("t1_done_row",   32'(cursor_row_o), 32'd0);
    chk("t1_done_ready", 32'(char_ready_o), 32'd1);

    // Vector table
    do_reset();
    slv_wait = 0;
    for (int i = 0; i < 15; i++) begin
      w0 = wr_addr.size();
      s0 = sel_cnt;
      send(tv[i].ch, tv[i].co);
      wait_idle(50, $sformatf("v%0d_idle", i));
      chk($sformatf("v%0d_col", i), 32'(cursor_col_o), 32'(tv[i].ecol));
      chk($sformatf("v%0d_row", i), 32'(cursor_row_o), 32'(tv[i].erow));
      chk($sformatf("v%0d_writes", i), 32'(wr_addr.size() - w0), tv[i].ewr ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_psel_cycles", i), 32'(sel_cnt - s0), tv[i].ewr ? 32'd2 : 32'd0);
      if (tv[i].ewr && wr_addr.size() > w0) begin
        chk($sformatf("v%0d_addr", i), wr_addr[$], tv[i].eaddr);
        chk($sformatf("v%0d_data", i), wr_data[$], tv[i].edata);
      end
    end

    // Full row, wrap to next line, newline wrap at bottom row
    do_reset();
    w0 = wr_addr.size();
    for (int i = 0; i < 80; i++) send(8'h61, 8'h05);
    wait_idle(50, "row_idle");
    chk("row_writes",    32'(wr_addr.size() - w0), 32'd80);
    chk("row_last_addr", wr_addr[$], 32'd79);
    chk("row_col",       32'(cursor_col_o), 32'd0);
    chk("row_row",       32'(cursor_row_o), 32'd1);
    for (int i = 0; i < 28; i++) send(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send(8'h62, 8'h05);
    wait_idle(50, "bot_idle");
    chk("bot_col", 32'(cursor_col_o), 32'd5);
    chk("bot_row", 32'(cursor_row_o), 32'd29);
    chk("bot_addr", wr_addr[$], 32'd2324);
    s0 = sel_cnt;
    send(8'h0A, 8'h00);
    chk("nl_wrap_col",  32'(cursor_col_o), 32'd0);
    chk("nl_wrap_row",  32'(cursor_row_o), 32'd0);
    chk("nl_wrap_psel", 32'(sel_cnt - s0), 32'd0);
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00);
    send(8'h08, 8'h00);
    chk("bs0_col", 32'(cursor_col_o), 32'd0);
    chk("bs0_row", 32'(cursor_row_o), 32'd3);
    for (int i = 0; i < 7; i++) send(8'h63, 8'h05);
    wait_idle(50, "bs7_idle");
    send(8'h08, 8'h00);
    chk("bs7_col", 32'(cursor_col_o), 32'd6);
    chk("bs7_row", 32'(cursor_row_o), 32'd3);
    send(8'h0D, 8'h00);
    chk("cr_col", 32'(cursor_col_o), 32'd0);
    chk("cr_row", 32'(cursor_row_o), 32'd3);
    s0 = sel_cnt;
    send(8'h07, 8'h00);
    chk("bel_col",  32'(cursor_col_o), 32'd0);
    chk("bel_row",  32'(cursor_row_o), 32'd3);
    chk("bel_psel", 32'(sel_cnt - s0), 32'd0);

    // Clear screen with a competing char in the same cycle
    chk("pre_clr_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    w0 = wr_addr.size();
    clr_req_i = 1'b1;
    color_i = 8'h02;
    char_valid_i = 1'b1;
    char_i = 8'h5A;
    #1;
    chk("clr_char_ready", 32'(char_ready_o), 32'd0);
    @(negedge clk_i);
    clr_req_i = 1'b0;
    char_valid_i = 1'b0;
    chk("clr_busy", 32'(busy_o), 32'd1);
    repeat (20) @(negedge clk_i);
    clr_req_i = 1'b1;
    @(negedge clk_i);
    clr_req_i = 1'b0;
    wait_idle(10000, "clr_idle");
    chk("clr_writes", 32'(wr_addr.size() - w0), 32'd2400);
    bad = 0;
    for (int i = 0; i < 2400 && (w0 + i) < wr_addr.size(); i++) begin
      if (wr_addr[w0 + i] !== 32'(i) || wr_data[w0 + i] !== 32'h0000_0220) bad++;
    end
    chk("clr_content", 32'(bad), 32'd0);
    chk("clr_col", 32'(cursor_col_o), 32'd0);
    chk("clr_row", 32'(cursor_row_o), 32'd0);
    repeat (10) @(negedge clk_i);
    chk("clr_no_requeue_busy",  32'(busy_o), 32'd0);
    chk("clr_no_requeue_write", 32'(wr_addr.size() - w0), 32'd2400);

    // Sticky slave error
    slv_err = 1'b1;
    send(8'h45, 8'h0C);
    wait_idle(50, "err_idle");
    chk("err_set", 32'(err_o), 32'd1);
    slv_err = 1'b0;
    send(8'h46, 8'h0C);
    send(8'h47, 8'h0C);
    wait_idle(50, "err2_idle");
    chk("err_sticky", 32'(err_o), 32'd1);
    chk("err_cursor", 32'(cursor_col_o), 32'd3);
    do_reset();
    chk("err_cleared", 32'(err_o), 32'd0);

    // Stalled slave: timeout (if built in), then reset while in ACCESS
    send(8'h41, 8'h01);
    wait_idle(50, "stall_pre_idle");
    slv_hang = 1'b1;
    send(8'h42, 8'h01);
    @(negedge clk_i);
`ifdef APB_TEXT_CONSOLE_TIMEOUT_EN
    acc = 0;
    while (apb_penable_o && acc < 20) begin
      acc++;
      @(negedge clk_i);
    end
    chk("tmo_access_cycles", 32'(acc), 32'd4);
    chk("tmo_psel",  32'(apb_psel_o),   32'd0);
    chk("tmo_err",   32'(err_o),        32'd1);
    chk("tmo_col",   32'(cursor_col_o), 32'd2);
    chk("tmo_ready", 32'(char_ready_o), 32'd1);
    send(8'h43, 8'h01);
    @(negedge clk_i);
`else
    acc = 0;
    repeat (10) @(negedge clk_i);
    chk("stall_penable", 32'(apb_penable_o), 32'd1);
    chk("stall_psel",    32'(apb_psel_o),    32'd1);
    chk("stall_col",     32'(cursor_col_o),  32'd1);
`endif
    chk("pre_rst_penable", 32'(apb_penable_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_psel",    32'(apb_psel_o),    32'd0);
    chk("midrst_penable", 32'(apb_penable_o), 32'd0);
    chk("midrst_col",     32'(cursor_col_o),  32'd0);
    chk("midrst_row",     32'(cursor_row_o),  32'd0);
    chk("midrst_busy",    32'(busy_o),        32'd0);
    chk("midrst_err",     32'(err_o),         32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    slv_hang = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_text_console.md
Name: apb_text_console

Overview:
- APB master that sits directly upstream of the APB character-generator slave and drives its character/colour map.
- Accepts a stream of character codes with a colour attribute on a valid/ready interface.
- Keeps a text cursor on the 80x30 grid and turns each printable character into one APB write of {colour, char} at the cursor cell.
- Handles control codes: newline, carriage return, backspace, plus a full-screen clear command.

Parameters:
- APB_ADDR_WIDTH, 13: width of apb_paddr_o.
- APB_DATA_WIDTH, 32: width of apb_pwdata_o.
- ADDR_SHIFT, 0: cell index is left-shifted by this amount to form apb_paddr_o; excess high bits are truncated.
- COLS, 80: characters per row.
- ROWS, 30: rows per screen.
- TIMEOUT_CYCLES, 255: ACCESS-phase cycle limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- char_valid_i  in  1  character request valid.
- char_i  in  8  character code.
- color_i  in  8  colour attribute; sampled on char or clear acceptance.
- char_ready_o  out  1  request accepted when valid&ready.
- clr_req_i  in  1  one-cycle clear-screen request.
- busy_o  out  1  APB transfer or clear in progress.
- cursor_col_o  out  7  current column.
- cursor_row_o  out  5  current row.
- err_o  out  1  sticky error flag.
- apb_paddr_o  out  APB_ADDR_WIDTH  APB address.
- apb_pwdata_o  out  APB_DATA_WIDTH  APB write data.
- apb_pwrite_o  out  1  APB write strobe.
- apb_psel_o  out  1  APB select.
- apb_penable_o  out  1  APB enable.
- apb_pready_i  in  1  APB ready.
- apb_pslverr_i  in  1  APB slave error.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, cursor (0,0), err_o 0. char_ready_o is forced 0 while rst_i is high.
- FSM states: IDLE, SETUP, ACCESS, CLR_NEXT.
- IDLE: char_ready_o=1 unless clr_req_i is high.
  - clr_req_i has priority: latch color_i, clear index=0, go to SETUP in clear mode. A char presented in the same cycle is not accepted.
- Accepted char handling:
  - 0x20..0x7E: latch {color_i, char_i}, index=row*COLS+col, go to SETUP.
  - 0x0A: col=0, row+1. No APB access; stays IDLE and ready again next cycle.
  - 0x0D: col=0.
  - 0x08: col-1 if col>0, else no change.
  - Any other code: accepted and discarded.
- SETUP (1 cycle): psel=1, penable=0, pwrite=1, paddr=index<<ADDR_SHIFT, pwdata={16'b0, color, char}. Address/data stay stable until ACCESS completes.
- ACCESS: psel=1, penable=1; hold until apb_pready_i=1.
  - On that edge: if apb_pslverr_i=1, set err_o.
  - Char mode: advance cursor, go to IDLE.
  - Clear mode: go to CLR_NEXT.
- CLR_NEXT (1 cycle, psel=0):
  - If index==COLS*ROWS-1: cursor to (0,0), go to IDLE.
  - Else index+1, go to SETUP. pwdata = {color, 0x20}.
  - A full clear is COLS*ROWS writes; at minimum 3 cycles per cell.
- Cursor advance: col+1. When col reaches COLS: col=0, row+1. Row wraps from ROWS-1 to 0, with no scrolling.
- busy_o = state != IDLE.
- err_o clears only on rst_i.
- Reset mid-transfer: psel/penable go low on the same edge and no completion is issued. The slave must tolerate the abandoned access.
- clr_req_i asserted while not IDLE: ignored (not queued).

Optional Feature:
- Macro APB_TEXT_CONSOLE_TIMEOUT_EN.
- Defined: a counter runs in ACCESS. If apb_pready_i has not been seen after TIMEOUT_CYCLES cycles:
  - drop psel/penable, set err_o;
  - in char mode, still advance the cursor and return to IDLE;
  - in clear mode, continue with CLR_NEXT.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Reset, then char 0x41 with colour 0x1F, slave pready after 1 wait -> SETUP paddr=0, pwdata=0x00001F41; next cycle penable=1; cursor becomes (1,0); char_ready_o back to 1.
- 80 printable chars from (0,0) -> last write at index 79; cursor (0,1). Then 0x0A at (5,29) -> cursor (0,0), no psel.
- 0x08 at (0,3) -> cursor unchanged. 0x08 at (7,3) -> (6,3). 0x0D -> col 0. 0x07 -> accepted, no APB access, cursor unchanged.
- clr_req_i with color 0x02 and char_valid_i high in the same cycle -> char not accepted; 2400 writes of 0x00000220 at indices 0..2399; cursor (0,0); busy_o falls after the last write.
- Slave returns pslverr=1 on a write -> err_o=1 and stays 1 through later good writes until rst_i.
- Macro defined, TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 ACCESS cycles, err_o=1, cursor advances. rst_i asserted during ACCESS -> psel=0 next edge, cursor (0,0).
